// File: rtl/pixel_fetch_pkg.sv
`default_nettype none
// ============================================================================
// pixel_fetch_pkg
// Shared types and constants for the pixel fetch controller.
// Revision: 1.0
// ============================================================================
package pixel_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } fetch_state_t;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_WR   = 2'b01;
    localparam logic [1:0] CTRL_RD   = 2'b10;

    localparam int START_BIT = 0;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_ENG = 1'b1
    } owner_t;

    function automatic logic is_cpu_req(input logic [1:0] ctrl);
        return (ctrl == CTRL_WR) || (ctrl == CTRL_RD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pix_skid_buf.sv
`default_nettype none
// ============================================================================
// pix_skid_buf
// Two-entry valid/ready FIFO with synchronous flush (used with PIX_SKID_BUF_EN).
// Revision: 1.0
// ============================================================================
module pix_skid_buf #(
    parameter int WIDTH = 25
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared only by reset so the streamed data reads 0 out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// pixel_fetch_ctrl
// Arbitrates the pixel bank port between CPU and a sequential fetch engine
// that streams image words over valid/ready. PIX_SKID_BUF_EN adds a 2-entry
// output buffer with read-ahead.
// Revision: 1.0
// ============================================================================
module pixel_fetch_ctrl
    import pixel_fetch_pkg::*;
#(
    parameter int AMBA_WORD  = 24,
    parameter int ADDR_DEPTH = 12,
    parameter int IMG_BASE   = 1,
    parameter int NUM_WORDS  = 1023
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            cpu_control,
    input  logic [ADDR_DEPTH:0]   cpu_address,
    input  logic [AMBA_WORD-1:0]  cpu_wdata,
    output logic [AMBA_WORD-1:0]  cpu_rdata,
    output logic                  cpu_rvalid,
    output logic [1:0]            bank_control,
    output logic [ADDR_DEPTH:0]   bank_address,
    output logic [AMBA_WORD-1:0]  bank_wdata,
    input  logic [AMBA_WORD-1:0]  bank_rdata,
    input  logic [AMBA_WORD-1:0]  start_word,
    output logic [AMBA_WORD-1:0]  pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_last,
    output logic                  done
);

    localparam int AW = ADDR_DEPTH + 1;
    localparam logic [ADDR_DEPTH-1:0] c_last_idx = ADDR_DEPTH'(NUM_WORDS - 1);

    if (NUM_WORDS < 1 || NUM_WORDS > (2**ADDR_DEPTH) - IMG_BASE) begin : g_chk_num_words
        $error("pixel_fetch_ctrl: NUM_WORDS out of range for ADDR_DEPTH/IMG_BASE");
    end

    fetch_state_t          r_state;
    logic [ADDR_DEPTH-1:0] r_cnt;
    logic                  r_done;
    logic                  r_rd_pend;
    owner_t                r_rd_own;
    logic                  r_start_hist;
    logic                  r_hist_vld;
    logic                  w_cpu_req;
    logic                  w_eng_rd;
    logic                  w_start;
    logic                  w_start_edge;
    logic                  w_eng_data_vld;
    logic                  w_abort;
    logic [AW-1:0]         w_eng_addr;
    logic                  w_unused_start;

    assign w_unused_start = |start_word;
    assign w_start        = start_word[START_BIT];
    // History must hold one real post-reset sample before an edge can count.
    assign w_start_edge   = r_hist_vld && w_start && !r_start_hist;
    assign w_cpu_req      = is_cpu_req(cpu_control);
    assign w_eng_addr     = AW'(IMG_BASE) + {1'b0, r_cnt};
    assign w_abort        = !w_start &&
                            (r_state == S_REQ || r_state == S_WAIT || r_state == S_HOLD);

    assign bank_control = w_cpu_req ? cpu_control : (w_eng_rd ? CTRL_RD : CTRL_IDLE);
    assign bank_address = w_cpu_req ? cpu_address : (w_eng_rd ? w_eng_addr : '0);
    assign bank_wdata   = (cpu_control == CTRL_WR) ? cpu_wdata : '0;

    assign cpu_rvalid     = r_rd_pend && (r_rd_own == OWN_CPU);
    assign cpu_rdata      = cpu_rvalid ? bank_rdata : '0;
    assign w_eng_data_vld = r_rd_pend && (r_rd_own == OWN_ENG);
    assign done           = r_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_pend    <= 1'b0;
            r_rd_own     <= OWN_CPU;
            r_start_hist <= 1'b0;
            r_hist_vld   <= 1'b0;
        end else begin
            r_rd_pend    <= (bank_control == CTRL_RD);
            r_rd_own     <= w_cpu_req ? OWN_CPU : OWN_ENG;
            r_start_hist <= w_start;
            r_hist_vld   <= 1'b1;
        end
    end

`ifdef PIX_SKID_BUF_EN
    logic [ADDR_DEPTH-1:0] r_rcv_cnt;
    logic [1:0]            w_fifo_cnt;
    logic                  w_fifo_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_credit;
    logic                  w_unused_fifo_ready;
    logic [AMBA_WORD:0]    w_fifo_out;
    logic [2:0]            w_occ;

    assign w_push   = w_eng_data_vld && w_start && (r_state == S_REQ || r_state == S_HOLD);
    assign w_pop    = w_fifo_valid && pix_ready;
    // Occupancy after this edge; a new read is issued only if its slot stays free.
    assign w_occ    = {1'b0, w_fifo_cnt} + {2'b0, w_push} - {2'b0, w_pop};
    assign w_credit = (w_occ <= 3'd1);
    assign w_eng_rd = (r_state == S_REQ) && w_start && (cpu_control == CTRL_IDLE) && w_credit;

    pix_skid_buf #(
        .WIDTH (AMBA_WORD + 1)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_flush (w_abort),
        .i_valid (w_push),
        .i_data  ({(r_rcv_cnt == c_last_idx), bank_rdata}),
        .o_ready (w_unused_fifo_ready),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_out),
        .i_ready (pix_ready),
        .o_count (w_fifo_cnt)
    );

    assign pix_data  = w_fifo_out[AMBA_WORD-1:0];
    assign pix_valid = w_fifo_valid;
    assign pix_last  = w_fifo_valid && w_fifo_out[AMBA_WORD];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rcv_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start_edge) begin
                    r_state   <= S_REQ;
                    r_cnt     <= '0;
                    r_rcv_cnt <= '0;
                end
                S_REQ: if (w_abort) begin
                    r_state <= S_IDLE;
                end else begin
                    if (w_push) r_rcv_cnt <= r_rcv_cnt + 1'b1;
                    if (w_eng_rd) begin
                        if (r_cnt == c_last_idx) r_state <= S_HOLD;
                        else                     r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: if (w_abort) begin
                    r_state <= S_IDLE;
                end else begin
                    if (w_push) r_rcv_cnt <= r_rcv_cnt + 1'b1;
                    if (w_pop && w_fifo_out[AMBA_WORD]) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: if (!w_start) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    logic [AMBA_WORD-1:0] r_pix_data;
    logic                 r_pix_valid;
    logic                 r_pix_last;

    assign w_eng_rd  = (r_state == S_REQ) && w_start && (cpu_control == CTRL_IDLE);
    assign pix_data  = r_pix_data;
    assign pix_valid = r_pix_valid;
    assign pix_last  = r_pix_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start_edge) begin
                    r_state <= S_REQ;
                    r_cnt   <= '0;
                end
                S_REQ: if (w_abort)       r_state <= S_IDLE;
                       else if (w_eng_rd) r_state <= S_WAIT;
                S_WAIT: if (w_abort) begin
                    r_state <= S_IDLE;
                end else if (w_eng_data_vld) begin
                    r_pix_data  <= bank_rdata;
                    r_pix_valid <= 1'b1;
                    r_pix_last  <= (r_cnt == c_last_idx);
                    r_state     <= S_HOLD;
                end
                S_HOLD: if (w_abort) begin
                    r_pix_valid <= 1'b0;
                    r_pix_last  <= 1'b0;
                    r_state     <= S_IDLE;
                end else if (pix_ready) begin
                    r_pix_valid <= 1'b0;
                    r_pix_last  <= 1'b0;
                    if (r_pix_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_DONE: if (!w_start) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pixel_fetch_ctrl
// Randomized directed bench with a bank model and a frame-order reference.
// Revision: 1.0
// ============================================================================
module tb_pixel_fetch_ctrl;
    import pixel_fetch_pkg::*;

    localparam int AMBA = 24;
    localparam int AD   = 12;
    localparam int IB   = 1;
`ifdef PIX_SKID_BUF_EN
    localparam int NW   = 8;
    localparam bit SKID = 1'b1;
`else
    localparam int NW   = 4;
    localparam bit SKID = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      cpu_control;
    logic [AD:0]     cpu_address;
    logic [AMBA-1:0] cpu_wdata;
    logic [AMBA-1:0] cpu_rdata;
    logic            cpu_rvalid;
    logic [1:0]      bank_control;
    logic [AD:0]     bank_address;
    logic [AMBA-1:0] bank_wdata;
    logic [AMBA-1:0] bank_rdata;
    logic [AMBA-1:0] start_word;
    logic [AMBA-1:0] pix_data;
    logic            pix_valid;
    logic            pix_ready;
    logic            pix_last;
    logic            done;

    always #5 clock = ~clock;

    pixel_fetch_ctrl #(
        .AMBA_WORD  (AMBA),
        .ADDR_DEPTH (AD),
        .IMG_BASE   (IB),
        .NUM_WORDS  (NW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_control  (cpu_control),
        .cpu_address  (cpu_address),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_rvalid   (cpu_rvalid),
        .bank_control (bank_control),
        .bank_address (bank_address),
        .bank_wdata   (bank_wdata),
        .bank_rdata   (bank_rdata),
        .start_word   (start_word),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_last     (pix_last),
        .done         (done)
    );

    logic [AMBA-1:0] mem [0:(1<<(AD+1))-1];

    int total = 0;
    int bad   = 0;
    int exp_idx;
    int eng_issue;
    int hs_cnt;
    int first_hs_cyc;
    int last_hs_cyc;
    int cyc = 0;
    int n0;
    bit in_frame;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    // One clock: sample pre-edge, model the bank at the edge, check post-edge.
    task automatic step();
        logic            hs, hs_last, pv, pstart, prst, cpu_rd;
        logic [AMBA-1:0] hs_data, pd, cpu_req_data, bw;
        logic [1:0]      bc;
        logic [AD:0]     ba;
        #1;
        prst    = reset;
        hs      = pix_valid && pix_ready && !prst;
        hs_data = pix_data;
        hs_last = pix_last;
        pv      = pix_valid;
        pd      = pix_data;
        pstart  = start_word[0];
        bc      = bank_control;
        ba      = bank_address;
        bw      = bank_wdata;
        cpu_rd  = (cpu_control == CTRL_RD) && !prst;
        cpu_req_data = mem[cpu_address];
        if (!prst) begin
            if (cpu_control == CTRL_RD || cpu_control == CTRL_WR) begin
                chk("bank_ctl_pass", bc, cpu_control);
                chk("bank_addr_pass", ba, cpu_address);
            end else if (bc == CTRL_RD) begin
                chk("eng_rd_in_frame", in_frame && (eng_issue < NW), 1);
                chk("eng_rd_addr", ba, IB + eng_issue);
                eng_issue++;
            end else begin
                chk("bank_idle", bc, CTRL_IDLE);
            end
        end
        if (hs) begin
            chk("hs_in_frame", exp_idx < NW, 1);
            chk("pix_data", hs_data, mem[IB + exp_idx]);
            chk("pix_last", hs_last, exp_idx == NW - 1);
            if (exp_idx == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            exp_idx++;
            hs_cnt++;
        end
        @(posedge clock);
        cyc++;
        #1;
        if (bc == CTRL_RD)      bank_rdata = mem[ba];
        else if (bc == CTRL_WR) mem[ba] = bw;
        #1;
        chk("cpu_rvalid", cpu_rvalid, cpu_rd);
        if (cpu_rd) chk("cpu_rdata", cpu_rdata, cpu_req_data);
        if (pv && !hs && pstart && !prst) begin
            chk("hold_valid", pix_valid, 1);
            chk("hold_data", pix_data, pd);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
        chk({tag, "_bank_ctl"}, bank_control, 0);
        chk({tag, "_bank_addr"}, bank_address, 0);
        chk({tag, "_bank_wdata"}, bank_wdata, 0);
        chk({tag, "_pix_data"}, pix_data, 0);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_pix_last"}, pix_last, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic start_frame();
        exp_idx   = 0;
        eng_issue = 0;
        hs_cnt    = 0;
        in_frame  = 1'b1;
        start_word = 24'h1;
    endtask

    task automatic run_frame(input int bound, input bit cpu_rand, input bit ready_rand);
        for (int i = 0; i < bound; i++) begin
            if (done) break;
            cpu_control = (cpu_rand && ($urandom_range(0, 1) == 1)) ? CTRL_RD : CTRL_IDLE;
            cpu_address = ($urandom_range(0, 3) == 0) ? (AD+1)'($urandom_range(0, 8191)) : 13'd5;
            pix_ready   = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        cpu_control = CTRL_IDLE;
        pix_ready   = 1'b1;
        chk("frame_done", done, 1);
        chk("frame_words", hs_cnt, NW);
        chk("frame_reads", eng_issue, NW);
    endtask

    task automatic end_frame();
        start_word = 24'h0;
        in_frame   = 1'b0;
        step();
        step();
        chk("done_cleared", done, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << (AD + 1)); i++) mem[i] = AMBA'($urandom);
        reset       = 1'b1;
        cpu_control = CTRL_IDLE;
        cpu_address = '0;
        cpu_wdata   = '0;
        bank_rdata  = '0;
        start_word  = 24'h1;
        pix_ready   = 1'b0;
        in_frame    = 1'b0;
        exp_idx     = 0;
        eng_issue   = 0;
        hs_cnt      = 0;
        first_hs_cyc = 0;
        last_hs_cyc  = 0;

        // Reset with start already high: outputs zero, level must not start a frame.
        repeat (3) step();
        chk_zero("rst");
        reset     = 1'b0;
        pix_ready = 1'b1;
        repeat (8) step();
        chk("no_start_level", pix_valid, 0);
        chk("no_done_level", done, 0);
        start_word = 24'h0;
        step();

        // Clean frame, CPU idle, sink always ready.
        start_frame();
        run_frame(200, 1'b0, 1'b0);
        chk("throughput", last_hs_cyc - first_hs_cyc, SKID ? NW - 1 : 3 * (NW - 1));
        repeat (3) step();
        chk("done_holds", done, 1);
        end_frame();

        // CPU hogs the port, then random CPU reads and random backpressure.
        start_frame();
        cpu_control = CTRL_RD;
        cpu_address = 13'd5;
        repeat (6) step();
        chk("cpu_stall", eng_issue, 0);
        run_frame(600, 1'b1, 1'b1);
        end_frame();

        // Backpressure on word 2 for 10 cycles.
        start_frame();
        for (int i = 0; i < 100; i++) begin
            if (pix_valid && exp_idx == 2) break;
            step();
        end
        chk("stall_seen", pix_valid && (exp_idx == 2), 1);
        n0 = eng_issue;
        pix_ready = 1'b0;
        repeat (10) step();
        if (SKID) chk("stall_buffered", (eng_issue - exp_idx) <= 2, 1);
        else      chk("stall_no_reads", eng_issue, n0);
        pix_ready = 1'b1;
        run_frame(200, 1'b0, 1'b0);
        end_frame();

        // Abort while word 1 is in flight.
        start_frame();
        for (int i = 0; i < 100; i++) begin
            if (eng_issue == 2) break;
            step();
        end
        chk("abort_point", eng_issue, 2);
        start_word = 24'h0;
        in_frame   = 1'b0;
        step();
        chk("abort_valid_drop", pix_valid, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_no_done", done, 0);
        end
        chk("abort_drop", exp_idx, 1);

        // Reset mid-frame, then a full restart.
        start_frame();
        repeat (5) step();
        reset = 1'b1;
        step();
        in_frame = 1'b0;
        chk_zero("rst_mid");
        reset = 1'b0;
        repeat (4) step();
        chk("rst_level_no_start", pix_valid, 0);
        start_word = 24'h0;
        step();
        start_frame();
        run_frame(200, 1'b0, 1'b0);
        end_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
